ps2_kbd_fifo: RTL and testbench

PS/2 keyboard receiver that decodes complete key events and buffers them in a FIFO, so the CPU-side MMIO reader can poll without losing keystrokes. Each event carries:
- raw scancode
- ASCII translation
- make/break, extended and shift status

It sits between the PS/2 pins and the memory-mapped keyboard register block, and is parametrised on clock rate, timeout and FIFO depth.

---
 rtl/ps2_kbd_pkg.sv | 50 +++++
 rtl/ps2_kbd_fifo_rx_frame.sv | 62 ++++++
 rtl/ps2_kbd_fifo.sv | 118 +++++++++++
 tb/tb_ps2_kbd_fifo.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared PS/2 keyboard constants, event layout and scancode-to-ASCII translation.
package ps2_kbd_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_REL    = 8'hF0;
   localparam logic [7:0] PS2_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_RSHIFT = 8'h59;

   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} dec_state_t;

   typedef struct packed {
      logic       shift;
      logic       ext;
      logic       rel;
      logic [7:0] ascii;
      logic [7:0] code;
   } ps2_event_t;

   function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code, input logic shift, input logic ext);
      logic [7:0] l;
      logic [7:0] a;
      l = 8'h00;
      a = 8'h00;
      case (code)
         8'h1C: l = 8'h61;  8'h32: l = 8'h62;  8'h21: l = 8'h63;  8'h23: l = 8'h64;
         8'h24: l = 8'h65;  8'h2B: l = 8'h66;  8'h34: l = 8'h67;  8'h33: l = 8'h68;
         8'h43: l = 8'h69;  8'h3B: l = 8'h6A;  8'h42: l = 8'h6B;  8'h4B: l = 8'h6C;
         8'h3A: l = 8'h6D;  8'h31: l = 8'h6E;  8'h44: l = 8'h6F;  8'h4D: l = 8'h70;
         8'h15: l = 8'h71;  8'h2D: l = 8'h72;  8'h1B: l = 8'h73;  8'h2C: l = 8'h74;
         8'h3C: l = 8'h75;  8'h2A: l = 8'h76;  8'h1D: l = 8'h77;  8'h22: l = 8'h78;
         8'h35: l = 8'h79;  8'h1A: l = 8'h7A;
         default: l = 8'h00;
      endcase
      // main-row digits take their US-layout symbol under shift; numpad digits never do
      case (code)
         8'h45: a = shift ? 8'h29 : 8'h30;  8'h16: a = shift ? 8'h21 : 8'h31;
         8'h1E: a = shift ? 8'h40 : 8'h32;  8'h26: a = shift ? 8'h23 : 8'h33;
         8'h25: a = shift ? 8'h24 : 8'h34;  8'h2E: a = shift ? 8'h25 : 8'h35;
         8'h36: a = shift ? 8'h5E : 8'h36;  8'h3D: a = shift ? 8'h26 : 8'h37;
         8'h3E: a = shift ? 8'h2A : 8'h38;  8'h46: a = shift ? 8'h28 : 8'h39;
         8'h70: a = 8'h30;  8'h69: a = 8'h31;  8'h72: a = 8'h32;  8'h7A: a = 8'h33;
         8'h6B: a = 8'h34;  8'h73: a = 8'h35;  8'h74: a = 8'h36;  8'h6C: a = 8'h37;
         8'h75: a = 8'h38;  8'h7D: a = 8'h39;
         8'h66: a = 8'h08;  8'h5A: a = 8'h0D;  8'h29: a = 8'h20;
         default: a = 8'h00;
      endcase
      return ext ? ((code == 8'h5A) ? 8'h0D : 8'h00) : (l != 8'h00) ? (shift ? l - 8'h20 : l) : a;
   endfunction

endpackage

// File: rtl/ps2_kbd_fifo_rx_frame.sv
// ps2_rx_frame: synchronises the PS/2 pins, assembles 11-bit frames and strobes valid/error per frame.
module ps2_rx_frame #(
   parameter int TO_CYC = 6000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       frame_valid,
   output logic       frame_err,
   output logic [7:0] data
);

   localparam int TW = $clog2(TO_CYC + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TO_CYC);

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          clk_prev;
   logic [10:0]   sr;
   logic [3:0]    bit_cnt;
   logic [TW-1:0] timer;
   logic          fall;
   logic          tgl;
   logic          timeout;
   logic          ok;

   assign fall    = clk_prev & ~clk_sync[1];
   assign tgl     = clk_prev ^ clk_sync[1];
   assign timeout = (timer == TO_MAX) && (bit_cnt != 4'd0) && clk_sync[1];
   assign ok      = ~sr[0] & sr[10] & ^sr[9:1];

   // bits enter at the top so the start bit ends up in sr[0] after eleven shifts
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         clk_sync    <= '1;
         dat_sync    <= '1;
         clk_prev    <= 1'b1;
         sr          <= '0;
         bit_cnt     <= '0;
         timer       <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         data        <= '0;
      end else begin
         clk_sync    <= {clk_sync[0], ps2_clk};
         dat_sync    <= {dat_sync[0], ps2_data};
         clk_prev    <= clk_sync[1];
         timer       <= tgl ? '0 : (timer == TO_MAX) ? timer : timer + 1'b1;
         frame_valid <= (bit_cnt == 4'd11) && ok;
         frame_err   <= (bit_cnt == 4'd11) && !ok;
         if (bit_cnt == 4'd11) begin
            bit_cnt <= '0;
            data    <= sr[8:1];
         end else if (fall) begin
            sr      <= {dat_sync[1], sr[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
         end else if (timeout)
            bit_cnt <= '0;
      end

endmodule

// File: rtl/ps2_kbd_fifo.sv
// ps2_kbd_fifo: decodes PS/2 prefix/shift sequences into key events and buffers them in an FWFT FIFO.
module ps2_kbd_fifo
   import ps2_kbd_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int TIMEOUT_US = 120,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd_en,
   input  logic       ovf_clr,
   output logic [7:0] ev_code,
   output logic [7:0] ev_ascii,
   output logic       ev_released,
   output logic       ev_extended,
   output logic       ev_shift,
   output logic       empty,
   output logic       full,
   output logic       overflow,
   output logic [7:0] err_cnt
);

   localparam int TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

   logic          frame_valid;
   logic          frame_err;
   logic [7:0]    data;
   dec_state_t    state;
   dec_state_t    state_nxt;
   logic          shift;
   logic          shift_nxt;
   logic          is_ext;
   logic          is_rel;
   logic          push;
   logic          pop;
   logic          wr;
   ps2_event_t    ev_in;
   ps2_event_t    head;
   ps2_event_t    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;

   ps2_rx_frame #(.TO_CYC(TO_CYC)) u_rx (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .data        (data)
   );

   // the event records shift as updated by this very byte, so a shift make reports shift=1
   always_comb begin
      state_nxt = state;
      shift_nxt = shift;
      push      = 1'b0;
      is_ext    = (state == GOT_E0) || (state == GOT_E0F0);
      is_rel    = (state == GOT_F0) || (state == GOT_E0F0);
      if (frame_err)
         state_nxt = IDLE;
      else if (frame_valid) begin
         if (data == PS2_EXT)
            state_nxt = GOT_E0;
         else if (data == PS2_REL)
            state_nxt = is_ext ? GOT_E0F0 : GOT_F0;
         else begin
            state_nxt = IDLE;
            push      = 1'b1;
            if (!is_ext && (data == PS2_LSHIFT || data == PS2_RSHIFT))
               shift_nxt = !is_rel;
         end
      end
      ev_in = '{shift: shift_nxt, ext: is_ext, rel: is_rel,
                ascii: ps2_to_ascii(data, shift_nxt, is_ext), code: data};
   end

   assign empty = (count == '0);
   assign full  = (count == DEPTH);
   assign pop   = rd_en & ~empty;
   assign wr    = push & (~full | pop);
   assign head  = empty ? '0 : mem[rptr];

   assign ev_code     = head.code;
   assign ev_ascii    = head.ascii;
   assign ev_released = head.rel;
   assign ev_extended = head.ext;
   assign ev_shift    = head.shift;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         shift    <= 1'b0;
         err_cnt  <= '0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         shift    <= shift_nxt;
         err_cnt  <= (frame_err && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
         wptr     <= wr ? wptr + 1'b1 : wptr;
         rptr     <= pop ? rptr + 1'b1 : rptr;
         count    <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
         overflow <= (push & full & ~pop) | (overflow & ~ovf_clr);
      end

   always_ff @(posedge clk)
      if (wr) mem[wptr] <= ev_in;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// tb_ps2_kbd_fifo: directed and randomized PS/2 frame stimulus checked against a keyboard event model.
module tb_ps2_kbd_fifo;

   localparam int TO_CYC = 50;
   localparam int HALF   = 10;
   localparam int DEPTH  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_en = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] ev_code;
   logic [7:0] ev_ascii;
   logic       ev_released;
   logic       ev_extended;
   logic       ev_shift;
   logic       empty;
   logic       full;
   logic       overflow;
   logic [7:0] err_cnt;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   ps2_kbd_fifo #(.CLK_HZ(1000000), .TIMEOUT_US(TO_CYC), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rd_en       (rd_en),
      .ovf_clr     (ovf_clr),
      .ev_code     (ev_code),
      .ev_ascii    (ev_ascii),
      .ev_released (ev_released),
      .ev_extended (ev_extended),
      .ev_shift    (ev_shift),
      .empty       (empty),
      .full        (full),
      .overflow    (overflow),
      .err_cnt     (err_cnt)
   );

   typedef struct {
      logic [7:0] code;
      logic [7:0] ascii;
      logic       rel;
      logic       ext;
      logic       shift;
   } exp_t;

   exp_t exp_q[$];
   logic m_ext = 1'b0;
   logic m_rel = 1'b0;
   logic m_shift = 1'b0;
   int   m_err = 0;

   logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_main [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] digit_pad  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
   logic [7:0] digit_sym  [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};

   function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic sh, input logic ex);
      if (ex) return (c == 8'h5A) ? 8'h0D : 8'h00;
      for (int i = 0; i < 26; i++)
         if (c == letter_codes[i]) return (sh ? 8'h41 : 8'h61) + 8'(i);
      for (int i = 0; i < 10; i++)
         if (c == digit_main[i]) return sh ? digit_sym[i] : 8'h30 + 8'(i);
      for (int i = 0; i < 10; i++)
         if (c == digit_pad[i]) return 8'h30 + 8'(i);
      if (c == 8'h66) return 8'h08;
      if (c == 8'h5A) return 8'h0D;
      if (c == 8'h29) return 8'h20;
      return 8'h00;
   endfunction

   task automatic model_frame(input logic [7:0] b, input bit bad_par);
      exp_t e;
      if (bad_par) begin
         m_err = (m_err < 255) ? m_err + 1 : 255;
         m_ext = 1'b0;
         m_rel = 1'b0;
      end else if (b == 8'hE0)
         m_ext = 1'b1;
      else if (b == 8'hF0)
         m_rel = 1'b1;
      else begin
         if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_rel;
         e.code  = b;
         e.ascii = ref_ascii(b, m_shift, m_ext);
         e.rel   = m_rel;
         e.ext   = m_ext;
         e.shift = m_shift;
         exp_q.push_back(e);
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input bit bad_par, input int n);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < n; i++) begin
         @(negedge clk) ps2_data = f[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par);
      send_bits(b, bad_par, 11);
      repeat (8) @(negedge clk);
      model_frame(b, bad_par);
   endtask

   task automatic pop_head();
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
      total++; if ({ev_code, ev_ascii, ev_released, ev_extended, ev_shift} !== 19'h0) begin
         bad++; $display("FAIL reset_ev: got %h/%h/%b%b%b want 0", ev_code, ev_ascii, ev_released, ev_extended, ev_shift);
      end
      total++; if (overflow !== 1'b0 || err_cnt !== 8'h00) begin
         bad++; $display("FAIL reset_flags: got ovf=%b err=%h want 0/00", overflow, err_cnt);
      end
      @(negedge clk) rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single();
      send_bits(8'h16, 1'b0, 10);
      @(negedge clk) ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL latency_early: got empty=%b want 1", empty); end
      @(posedge clk);
      #1;
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL latency_3cyc: got empty=%b want 0", empty); end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      model_frame(8'h16, 1'b0);
      repeat (4) @(negedge clk);
      total++; if ({ev_code, ev_ascii} !== 16'h1631 || {ev_released, ev_extended, ev_shift} !== 3'b000) begin
         bad++; $display("FAIL single_ev: got %h/%h/%b%b%b want 16/31/000", ev_code, ev_ascii, ev_released, ev_extended, ev_shift);
      end
      pop_head();
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_pop: got empty=%b want 1", empty); end
      exp_q.delete();
   endtask

   task automatic test_shift();
      logic [7:0] codes [4] = '{8'h12, 8'h1E, 8'h1E, 8'h12};
      logic [7:0] ascii [4] = '{8'h00, 8'h40, 8'h00, 8'h00};
      logic [1:0] rs [4] = '{2'b01, 2'b01, 2'b11, 2'b10};
      send_frame(8'h12, 1'b0);
      send_frame(8'h1E, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1E, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h12, 1'b0);
      for (int i = 0; i < 4; i++) begin
         total++; if (ev_code !== codes[i] || {ev_released, ev_shift} !== rs[i] || ev_extended !== 1'b0 || empty !== 1'b0) begin
            bad++; $display("FAIL shift_ev%0d: got %h rel/sh=%b%b ext=%b empty=%b want %h %b 0 0", i, ev_code, ev_released, ev_shift, ev_extended, empty, codes[i], rs[i]);
         end
         if (i != 2) begin
            total++; if (ev_ascii !== ascii[i]) begin bad++; $display("FAIL shift_ascii%0d: got %h want %h", i, ev_ascii, ascii[i]); end
         end
         pop_head();
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL shift_count: got empty=%b want 1", empty); end
      exp_q.delete();
   endtask

   task automatic test_extended();
      send_frame(8'hE0, 1'b0);
      send_frame(8'h5A, 1'b0);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h5A, 1'b0);
      total++; if ({ev_code, ev_ascii} !== 16'h5A0D || {ev_extended, ev_released} !== 2'b10) begin
         bad++; $display("FAIL ext_make: got %h/%h ext/rel=%b%b want 5A/0D 10", ev_code, ev_ascii, ev_extended, ev_released);
      end
      pop_head();
      total++; if (ev_code !== 8'h5A || {ev_extended, ev_released} !== 2'b11 || empty !== 1'b0) begin
         bad++; $display("FAIL ext_break: got %h ext/rel=%b%b empty=%b want 5A 11 0", ev_code, ev_extended, ev_released, empty);
      end
      pop_head();
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL ext_count: got empty=%b want 1", empty); end
      exp_q.delete();
   endtask

   task automatic test_timeout();
      send_bits(8'h3C, 1'b0, 5);
      repeat (TO_CYC + 10) @(negedge clk);
      send_frame(8'h45, 1'b0);
      total++; if ({ev_code, ev_ascii} !== 16'h4530 || empty !== 1'b0) begin
         bad++; $display("FAIL timeout_ev: got %h/%h empty=%b want 45/30 0", ev_code, ev_ascii, empty);
      end
      pop_head();
      total++; if (empty !== 1'b1 || err_cnt !== 8'h00) begin
         bad++; $display("FAIL timeout_after: got empty=%b err=%h want 1/00", empty, err_cnt);
      end
      exp_q.delete();
   endtask

   task automatic test_parity();
      send_frame(8'h1C, 1'b1);
      send_frame(8'h1C, 1'b0);
      total++; if (err_cnt !== 8'h01) begin bad++; $display("FAIL parity_err_cnt: got %h want 01", err_cnt); end
      total++; if ({ev_code, ev_ascii} !== 16'h1C61 || empty !== 1'b0) begin
         bad++; $display("FAIL parity_ev: got %h/%h empty=%b want 1C/61 0", ev_code, ev_ascii, empty);
      end
      pop_head();
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL parity_count: got empty=%b want 1", empty); end
      exp_q.delete();
   endtask

   task automatic test_overflow();
      logic [7:0] codes [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
      logic [7:0] after [8] = '{8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h45};
      for (int i = 0; i < 9; i++) send_frame(codes[i], 1'b0);
      total++; if (full !== 1'b1 || overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_set: got full=%b ovf=%b want 1/1", full, overflow);
      end
      total++; if (ev_code !== 8'h16) begin bad++; $display("FAIL ovf_head: got %h want 16", ev_code); end
      @(negedge clk) ovf_clr = 1'b1;
      @(negedge clk) ovf_clr = 1'b0;
      total++; if (overflow !== 1'b0 || full !== 1'b1) begin
         bad++; $display("FAIL ovf_clr: got ovf=%b full=%b want 0/1", overflow, full);
      end
      send_bits(8'h45, 1'b0, 10);
      @(negedge clk) ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
      total++; if (full !== 1'b1 || overflow !== 1'b0 || ev_code !== 8'h1E) begin
         bad++; $display("FAIL push_pop_full: got full=%b ovf=%b head=%h want 1/0/1E", full, overflow, ev_code);
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         total++; if (ev_code !== after[i] || empty !== 1'b0) begin
            bad++; $display("FAIL ovf_order%0d: got %h empty=%b want %h 0", i, ev_code, empty, after[i]);
         end
         pop_head();
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_drain: got empty=%b want 1", empty); end
      exp_q.delete();
   endtask

   task automatic test_random();
      logic [7:0] c;
      exp_t e;
      for (int g = 0; g < 40; g++) begin
         if ($urandom_range(3) == 0) send_frame(8'hE0, $urandom_range(9) == 0);
         if ($urandom_range(2) == 0) send_frame(8'hF0, $urandom_range(9) == 0);
         case ($urandom_range(5))
            0: c = letter_codes[$urandom_range(25)];
            1: c = digit_main[$urandom_range(9)];
            2: c = digit_pad[$urandom_range(9)];
            3: c = $urandom_range(1) ? 8'h12 : 8'h59;
            4: c = ($urandom_range(2) == 0) ? 8'h66 : ($urandom_range(1) ? 8'h5A : 8'h29);
            default: begin
               c = 8'($urandom);
               if (c == 8'hE0 || c == 8'hF0) c = 8'h00;
            end
         endcase
         send_frame(c, $urandom_range(9) == 0);
         if (g % 4 == 3) begin
            while (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               total++; if (empty !== 1'b0 || ev_code !== e.code || ev_ascii !== e.ascii ||
                            {ev_released, ev_extended, ev_shift} !== {e.rel, e.ext, e.shift}) begin
                  bad++; $display("FAIL rand_ev g%0d: got e=%b %h/%h %b%b%b want %h/%h %b%b%b", g, empty, ev_code, ev_ascii,
                                  ev_released, ev_extended, ev_shift, e.code, e.ascii, e.rel, e.ext, e.shift);
               end
               pop_head();
            end
            total++; if (empty !== 1'b1 || err_cnt !== 8'(m_err)) begin
               bad++; $display("FAIL rand_drain g%0d: got empty=%b err=%h want 1/%h", g, empty, err_cnt, 8'(m_err));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      send_frame(8'h16, 1'b0);
      send_bits(8'h1E, 1'b0, 4);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      total++; if (empty !== 1'b1 || ev_code !== 8'h00 || err_cnt !== 8'h00) begin
         bad++; $display("FAIL reset_mid: got empty=%b code=%h err=%h want 1/00/00", empty, ev_code, err_cnt);
      end
      @(negedge clk) rst = 1'b0;
      exp_q.delete();
      m_ext = 1'b0;
      m_rel = 1'b0;
      m_shift = 1'b0;
      m_err = 0;
      repeat (4) @(negedge clk);
      send_frame(8'h1C, 1'b0);
      total++; if ({ev_code, ev_ascii} !== 16'h1C61 || err_cnt !== 8'h00) begin
         bad++; $display("FAIL reset_mid_after: got %h/%h err=%h want 1C/61/00", ev_code, ev_ascii, err_cnt);
      end
      pop_head();
   endtask

   initial begin
      test_reset();
      test_single();
      test_shift();
      test_extended();
      test_timeout();
      test_parity();
      test_overflow();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
